// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor
//
// Bit-serial ripple-borrow subtractor. Computes d = a - b one bit per clock,
// LSB first, through one full-subtractor cell and a borrow flip-flop. Each
// operation takes WIDTH cycles from the accepting edge to the done edge.
//
// Optional feature macro: SUB_OVF_EN adds the signed-overflow output ovf.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  operation request, sampled only while idle
//   a, b   minuend / subtrahend, captured on an accepted start
//   busy   high while an operation is in progress
//   done   one-cycle pulse; d/bout (and ovf) updated on the same edge
//   d      difference, (a - b) mod 2^WIDTH
//   bout   final borrow, 1 iff a < b (unsigned)
//   ovf    signed overflow (SUB_OVF_EN only)
module serial_ripple_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the WIDTH-1 lower result bits; the top bit joins them on the last cycle.
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic ai, bi, diff, br_next, last;

`ifdef SUB_OVF_EN
  // Operand sign bits, kept because the operand registers shift them away.
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // Full-subtractor cell.
  assign ai      = a_sh_q[0];
  assign bi      = b_sh_q[0];
  assign diff    = ai ^ bi ^ br_q;
  assign br_next = (~ai & bi) | (~(ai ^ bi) & br_q);
  assign last    = (cnt_q == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
`ifdef SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
`ifdef SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end

      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = (WIDTH-1)'({diff, res_q} >> 1);
        br_d   = br_next;
        if (last) begin
          // Publish the complete result only now; d never shows partial bits.
          d_d     = {diff, res_q};
          bout_d  = br_next;
          done_d  = 1'b1;
          state_d = StIdle;
`ifdef SUB_OVF_EN
          ovf_d   = (a_msb_q != b_msb_q) && (diff != a_msb_q);
`endif
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
`ifdef SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
